// File: rtl/sram_ctrl_seq.sv
// sram_ctrl_seq: one-at-a-time command sequencer serialising writes and timing reads for sram_top
module sram_ctrl_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_is_read,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  sram_serial_in,
  output logic                  sram_shift,
  output logic                  sram_w_en,
  output logic                  sram_r_en,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_data_out,
  input  logic                  sram_data_valid
);
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, SHIFT, WRITE, READ, WAIT_RD, RESP} state_t;
  state_t state, next;
  logic live;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, data_q;
  logic [BW-1:0] bit_cnt;
  logic [TW-1:0] to_cnt;
  logic is_rd_q, err_q;
  logic accept, to_last;
  assign accept  = state == IDLE && live && cmd_valid;
  assign to_last = to_cnt == TW'(RD_TIMEOUT - 1);
  // state register; live keeps cmd_ready low until the first cycle after reset
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state <= IDLE;
      live  <= 1'b0;
    end else begin
      state <= next;
      live  <= 1'b1;
    end
  end
  // next-state decode
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = accept ? (cmd_we ? SHIFT : READ) : IDLE;
      SHIFT:   next = bit_cnt == '0 ? WRITE : SHIFT;
      WRITE:   next = RESP;
      READ:    next = WAIT_RD;
      WAIT_RD: next = (sram_data_valid || to_last) ? RESP : WAIT_RD;
      RESP:    next = rsp_ready ? IDLE : RESP;
      default: next = IDLE;
    endcase
  end
  // outputs decoded purely from registered state so no input reaches an output combinationally
  always_comb begin
    cmd_ready      = state == IDLE && live;
    busy           = state != IDLE;
    sram_shift     = state == SHIFT;
    sram_serial_in = state == SHIFT && wdata_q[bit_cnt];
    sram_w_en      = state == WRITE;
    sram_r_en      = state == READ;
    sram_addr      = state != IDLE ? addr_q : '0;
    rsp_valid      = state == RESP;
    rsp_is_read    = state == RESP && is_rd_q;
    rsp_err        = state == RESP && err_q;
    rsp_data       = state == RESP ? data_q : '0;
  end
  // command latch, bit/timeout counters and response capture
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      bit_cnt <= '0;
      to_cnt  <= '0;
      is_rd_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          addr_q  <= cmd_addr;
          wdata_q <= cmd_we ? cmd_wdata : '0;
          data_q  <= '0;
          bit_cnt <= BW'(DATA_WIDTH - 1);
          to_cnt  <= '0;
          is_rd_q <= !cmd_we;
          err_q   <= 1'b0;
        end
        SHIFT: bit_cnt <= bit_cnt - 1'b1;
        WAIT_RD: begin
          if (sram_data_valid) data_q <= sram_data_out;
          else if (to_last) err_q <= 1'b1;
          else to_cnt <= to_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
